adc_lvds_frame_gen: RTL and testbench
=====================================

Name: adc_lvds_frame_gen

Overview:
Parametrised, synthesizable emulator of a multi-channel serial-LVDS ADC of the AD9222 type. Generates frame clock (FCO), bit clock (DCO) and per-channel serial data with a selectable test pattern.
Used in two places:
- In testbenches, replacing hand-written FCO/DCO/data stimulus.
- In-FPGA, as a loopback source for the deserializer and bitslip logic.
Compared with the fixed 8-channel, 12-bit, all-"100000000000" stimulus it replaces, it adds configurable channel count, sample width and pattern modes, plus a frame counter.

Parameters:
N_CH, 8, number of serial data channels (1..16)
BITS, 12, bits per sample/frame; even, 8..16
RAMP_STEP, 1, per-channel offset added in ramp mode (channel k starts at k*RAMP_STEP)

Ports:
CLK  in  1  bit-rate clock; one serial bit per cycle
RSTn  in  1  asynchronous active-low reset
EN  in  1  run request; sampled at frame boundaries
MODE  in  2  0=fixed, 1=ramp, 2=checkerboard, 3=PRBS (see Optional Feature)
PATTERN  in  BITS  fixed word for MODE 0
FCO  out  1  frame clock
DCO  out  1  bit clock
DOUT  out  N_CH  serial data, MSB first
FRAME_START  out  1  one-cycle pulse coincident with bit 0 of each frame
ACTIVE  out  1  high while a frame is being shifted
FRAME_CNT  out  16  completed-frame counter

Behaviour:
- Clock and reset: one clock CLK; reset RSTn is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - Bit index 0, ramp counter 0, FRAME_CNT 0, LFSR 9'h1FF.
  - Applies immediately on RSTn low, including mid-frame; no partial-frame completion.
- States: IDLE, SHIFT.
- IDLE:
  - FCO=DCO=DOUT=ACTIVE=0.
  - If EN=1 at a rising edge, go to SHIFT.
  - On that same edge: load each channel's shift register, latch MODE, latch PATTERN.
  - Bit 0 appears on DOUT at that edge (latency 1 cycle from EN), with FRAME_START=1 and ACTIVE=1.
- SHIFT:
  - Bit index counts 0..BITS-1; one bit per cycle on every channel, MSB first.
  - FCO=1 for bit indices 0..BITS/2-1 and 0 otherwise.
  - DCO=1 on even bit indices and 0 on odd; it toggles every cycle.
- Frame end (bit index BITS-1):
  - FRAME_CNT increments; 16-bit wrap from 16'hFFFF to 0.
  - Ramp counter increments modulo 2^BITS.
  - If EN=1: reload, re-latch MODE and PATTERN, and emit bit 0 of the next frame on the following cycle. Frames are back-to-back with no gap.
  - If EN=0: return to IDLE and drop ACTIVE on the following cycle.
- EN deassertion mid-frame: the current frame always completes.
- MODE/PATTERN changes mid-frame: ignored until the next load.
- Word per channel k at load:
  - Mode 0: PATTERN.
  - Mode 1: (ramp_cnt + k*RAMP_STEP) mod 2^BITS.
  - Mode 2: alternating frames of 1010..(MSB=1) and 0101..; the first frame after IDLE is 1010...
- All outputs are registered; no combinational path from inputs to outputs.

Optional Feature:
ADC_PRBS_EN
- Defined:
  - MODE 3 selects PRBS-9 (x^9+x^5+1), one shared LFSR.
  - Advances one step per SHIFT cycle while latched MODE=3.
  - All channels output lfsr[8]; the LFSR does not reset on IDLE, only on RSTn.
- Undefined:
  - MODE 3 behaves exactly as MODE 0.
  - No LFSR logic is synthesized.

Test Plan:
- Reset then EN=1, MODE=0, PATTERN=12'h800, N_CH=8:
  - DOUT=8'hFF on bit 0, 8'h00 on bits 1..11.
  - FCO high 6 cycles, low 6.
  - DCO 1,0,1,0,...
  - FRAME_START every 12 cycles; FRAME_CNT=3 after 36 cycles.
- MODE=1, RAMP_STEP=1: frame 0 ch0=0, ch3=3; frame 5 ch3=8.
  - BITS=12, after 4096 frames ch0 wraps back to 0.
- EN dropped at bit index 4:
  - Frame finishes through bit 11, ACTIVE=0 next cycle.
  - FRAME_CNT increments exactly once.
  - PATTERN changed at bit 4 is not used.
- RSTn pulsed low at bit index 7 of frame 2:
  - All outputs 0 asynchronously, FRAME_CNT=0.
  - After release with EN=1: bit 0 of a fresh frame with ramp restart at 0.
- MODE=2, 3 frames: words 12'hAAA, 12'h555, 12'hAAA on every channel.
- With ADC_PRBS_EN, MODE=3: the first 9 DOUT bits are all 1; the sequence repeats after 511 bits. Without the macro: output equals PATTERN.

Source files
------------

// File: rtl/adc_lvds_frame_gen_if.sv
// Bundle of run control, pattern selection and serial outputs for the
// AD9222-style serial ADC emulator. The generator uses the master view and
// a deserializer or testbench uses the slave view.
interface adc_lvds_frame_gen_if #(
    parameter int N_CH = 8,
    parameter int BITS = 12
);
    logic            EN;
    logic [1:0]      MODE;
    logic [BITS-1:0] PATTERN;
    logic            FCO;
    logic            DCO;
    logic [N_CH-1:0] DOUT;
    logic            FRAME_START;
    logic            ACTIVE;
    logic [15:0]     FRAME_CNT;

    modport master (
        input  EN, MODE, PATTERN,
        output FCO, DCO, DOUT, FRAME_START, ACTIVE, FRAME_CNT
    );

    modport slave (
        output EN, MODE, PATTERN,
        input  FCO, DCO, DOUT, FRAME_START, ACTIVE, FRAME_CNT
    );
endinterface

// File: rtl/adc_lvds_frame_gen.sv
// Multi-channel serial-LVDS ADC emulator (AD9222 style).
// One serial bit is produced per CLK cycle on every channel, MSB first.
// FCO is high for the first half of each frame. DCO toggles every bit.
// Modes: 0 = fixed PATTERN, 1 = per-channel ramp, 2 = checkerboard, and 3.
// Optional macro ADC_PRBS_EN makes mode 3 a shared PRBS-9 source.
// Without the macro, mode 3 behaves exactly like mode 0.
module adc_lvds_frame_gen #(
    parameter int N_CH      = 8,
    parameter int BITS      = 12,
    parameter int RAMP_STEP = 1
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    adc_lvds_frame_gen_if.master bus
);
    localparam int IW = $clog2(BITS);
    localparam logic [IW-1:0] LAST = IW'(BITS - 1);
    localparam logic [IW-1:0] HALF = IW'(BITS / 2);

    // Checkerboard word with MSB = 1 (1010...). BITS is even.
    function automatic logic [BITS-1:0] chk_word();
        logic [BITS-1:0] w;
        for (int i = 0; i < BITS; i++) w[i] = (i % 2) == 1;
        return w;
    endfunction

    localparam logic [BITS-1:0] CHK_A = chk_word();
    localparam logic [BITS-1:0] CHK_B = ~CHK_A;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                     state_q, state_d;
    logic [IW-1:0]              bit_idx_q, bit_idx_d;
    logic [BITS-1:0]            ramp_cnt_q, ramp_cnt_d;
    logic                       chk_q, chk_d;        // phase of last checkerboard load, 0 = 1010..
    logic [N_CH-1:0][BITS-1:0]  sreg_q, sreg_d;
    logic                       fco_q, fco_d;
    logic                       dco_q, dco_d;
    logic [N_CH-1:0]            dout_q, dout_d;
    logic                       fs_q, fs_d;
    logic                       active_q, active_d;
    logic [15:0]                frame_cnt_q, frame_cnt_d;
`ifdef ADC_PRBS_EN
    logic [1:0]                 mode_q, mode_d;
    logic [8:0]                 lfsr_q, lfsr_d;
    logic [1:0]                 emit_mode;
`endif

    // A load only happens from IDLE or at a frame end. At a frame end the ramp
    // has just advanced and the checkerboard flips. A start from IDLE keeps the
    // ramp value and restarts the checkerboard at 1010...
    logic                       ld_phase;
    logic [BITS-1:0]            ld_ramp;
    logic [N_CH-1:0][BITS-1:0]  load_word;
    logic                       load;

    assign ld_phase = (state_q == IDLE) ? 1'b0 : ~chk_q;
    assign ld_ramp  = (state_q == IDLE) ? ramp_cnt_q : ramp_cnt_q + BITS'(1);

    // Word each channel would load at this edge, from the live MODE and PATTERN
    always_comb begin
        load_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            case (bus.MODE)
                2'd1:    load_word[k] = ld_ramp + BITS'(k * RAMP_STEP);
                2'd2:    load_word[k] = ld_phase ? CHK_B : CHK_A;
                default: load_word[k] = bus.PATTERN;
            endcase
        end
    end

    // Frame sequencing: next state, shifting, frame end and reload
    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        ramp_cnt_d  = ramp_cnt_q;
        chk_d       = chk_q;
        sreg_d      = sreg_q;
        frame_cnt_d = frame_cnt_q;
        fco_d       = 1'b0;
        dco_d       = 1'b0;
        dout_d      = '0;
        fs_d        = 1'b0;
        active_d    = 1'b0;
        load        = 1'b0;
`ifdef ADC_PRBS_EN
        mode_d      = mode_q;
        lfsr_d      = lfsr_q;
        emit_mode   = mode_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.EN) load = 1'b1;
            end
            SHIFT: begin
                if (bit_idx_q == LAST) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    ramp_cnt_d  = ramp_cnt_q + BITS'(1);
                    if (bus.EN) load = 1'b1;
                    else        state_d = IDLE;
                end else begin
                    bit_idx_d = bit_idx_q + 1'b1;
                    for (int k = 0; k < N_CH; k++) begin
                        dout_d[k] = sreg_q[k][BITS-1];
                        sreg_d[k] = sreg_q[k] << 1;
                    end
                    fco_d    = bit_idx_d < HALF;
                    dco_d    = ~bit_idx_d[0];
                    active_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load) begin
            state_d   = SHIFT;
            bit_idx_d = '0;
            chk_d     = ld_phase;
            for (int k = 0; k < N_CH; k++) begin
                dout_d[k] = load_word[k][BITS-1];
                sreg_d[k] = load_word[k] << 1;
            end
            fco_d    = 1'b1;
            dco_d    = 1'b1;
            fs_d     = 1'b1;
            active_d = 1'b1;
        end

`ifdef ADC_PRBS_EN
        // PRBS-9 (x^9 + x^5 + 1). The LFSR steps once for every bit emitted in mode 3
        if (load) begin
            mode_d    = bus.MODE;
            emit_mode = bus.MODE;
        end
        if (active_d && emit_mode == 2'd3) begin
            dout_d = {N_CH{lfsr_q[8]}};
            lfsr_d = {lfsr_q[7:0], lfsr_q[8] ^ lfsr_q[4]};
        end
`endif
    end

    // State and registered outputs. Reset aborts any frame in progress
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            ramp_cnt_q  <= '0;
            chk_q       <= 1'b0;
            sreg_q      <= '0;
            fco_q       <= 1'b0;
            dco_q       <= 1'b0;
            dout_q      <= '0;
            fs_q        <= 1'b0;
            active_q    <= 1'b0;
            frame_cnt_q <= '0;
`ifdef ADC_PRBS_EN
            mode_q      <= 2'd0;
            lfsr_q      <= 9'h1FF;
`endif
        end else begin
            state_q     <= state_d;
            bit_idx_q   <= bit_idx_d;
            ramp_cnt_q  <= ramp_cnt_d;
            chk_q       <= chk_d;
            sreg_q      <= sreg_d;
            fco_q       <= fco_d;
            dco_q       <= dco_d;
            dout_q      <= dout_d;
            fs_q        <= fs_d;
            active_q    <= active_d;
            frame_cnt_q <= frame_cnt_d;
`ifdef ADC_PRBS_EN
            mode_q      <= mode_d;
            lfsr_q      <= lfsr_d;
`endif
        end
    end

    assign bus.FCO         = fco_q;
    assign bus.DCO         = dco_q;
    assign bus.DOUT        = dout_q;
    assign bus.FRAME_START = fs_q;
    assign bus.ACTIVE      = active_q;
    assign bus.FRAME_CNT   = frame_cnt_q;
endmodule

// File: tb/tb_adc_lvds_frame_gen.sv
// Testbench for adc_lvds_frame_gen. Expected serial streams come from
// per-frame words derived from the mode rules, then are checked bit by bit.
module tb_adc_lvds_frame_gen;
    localparam int N_CH      = 8;
    localparam int BITS      = 12;
    localparam int RAMP_STEP = 1;
    localparam int W         = 1 << BITS;
    localparam int OW        = 4 + N_CH + 16;

    typedef logic [N_CH-1:0][BITS-1:0] words_t;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    adc_lvds_frame_gen_if #(.N_CH(N_CH), .BITS(BITS)) bus ();

    adc_lvds_frame_gen #(.N_CH(N_CH), .BITS(BITS), .RAMP_STEP(RAMP_STEP)) dut (
        .CLK (CLK),
        .RSTn(RSTn),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int         m_frames;   // completed frames (mod 2^16)
    int         m_ramp;     // ramp base of the next frame
    bit         m_chk_b;    // next checkerboard frame is 0101..
    logic [8:0] m_lfsr;

    function automatic int chk_a_word();
        int w = 0;
        for (int i = 0; i < BITS; i++) w = w * 2 + ((i % 2 == 0) ? 1 : 0);
        return w;
    endfunction

    function automatic int exp_word(input int mode, input int pat, input int k);
        case (mode)
            1:       return (m_ramp + k * RAMP_STEP) % W;
            2:       return m_chk_b ? ((W - 1) ^ chk_a_word()) : chk_a_word();
            default: return pat;
        endcase
    endfunction

    function automatic logic [OW-1:0] observed();
        return {bus.FCO, bus.DCO, bus.FRAME_START, bus.ACTIVE, bus.DOUT, bus.FRAME_CNT};
    endfunction

    task automatic model_reset();
        m_frames = 0;
        m_ramp   = 0;
        m_chk_b  = 1'b0;
        m_lfsr   = 9'h1FF;
    endtask

    task automatic do_reset();
        bus.EN = 1'b0;
        RSTn   = 1'b0;
        model_reset();
        @(posedge CLK); #1;
        @(negedge CLK);
        RSTn = 1'b1;
        @(posedge CLK); #1;
    endtask

    // Run one frame (or its first n_bits bits) and check every cycle.
    // At poke_at, EN drops and MODE/PATTERN are disturbed mid-frame.
    task automatic check_frame(input int mode, input int pat, input int n_bits,
                               input int poke_at, output words_t got);
        int              w [N_CH];
        logic [N_CH-1:0] de;
        logic [OW-1:0]   exp_v, obs;
        got         = '0;
        bus.EN      = 1'b1;
        bus.MODE    = 2'(mode);
        bus.PATTERN = BITS'(pat);
        for (int k = 0; k < N_CH; k++) w[k] = exp_word(mode, pat, k);
        for (int i = 0; i < n_bits; i++) begin
            @(posedge CLK); #1;
            for (int k = 0; k < N_CH; k++) de[k] = w[k][BITS-1-i];
`ifdef ADC_PRBS_EN
            if (mode == 3) begin
                de     = {N_CH{m_lfsr[8]}};
                m_lfsr = {m_lfsr[7:0], m_lfsr[8] ^ m_lfsr[4]};
            end
`endif
            exp_v = {i < BITS / 2, i % 2 == 0, i == 0, 1'b1, de, 16'(m_frames)};
            obs   = observed();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL frame_bit mode%0d frame%0d bit%0d: got %h expected %h",
                         mode, m_frames, i, obs, exp_v);
            end
            for (int k = 0; k < N_CH; k++) got[k][BITS-1-i] = bus.DOUT[k];
            if (i == poke_at) begin
                bus.EN      = 1'b0;
                bus.PATTERN = ~bus.PATTERN;
                bus.MODE    = 2'($urandom_range(0, 3));
            end
        end
        if (n_bits == BITS) begin
            m_frames = (m_frames + 1) % 65536;
            m_ramp   = (m_ramp + 1) % W;
            m_chk_b  = !m_chk_b;
        end
    endtask

    task automatic check_idle(input int n);
        logic [OW-1:0] exp_v, obs;
        bus.EN      = 1'b0;
        bus.MODE    = 2'($urandom_range(0, 3));
        bus.PATTERN = BITS'($urandom);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            exp_v = {4'b0, {N_CH{1'b0}}, 16'(m_frames)};
            obs   = observed();
            n_tests++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL idle cycle%0d: got %h expected %h", i, obs, exp_v);
            end
        end
        m_chk_b = 1'b0;
    endtask

    task automatic test_reset();
        bus.EN = 1'b0; bus.MODE = 2'd0; bus.PATTERN = '0;
        model_reset();
        repeat (2) @(posedge CLK);
        #1;
        n_tests++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected 0", observed());
        end
        @(negedge CLK);
        RSTn = 1'b1;
        check_idle(3);
    endtask

    task automatic test_fixed();
        words_t got;
        for (int f = 0; f < 3; f++) begin
            check_frame(0, 12'h800, BITS, -1, got);
            n_tests++;
            if (got !== {N_CH{12'h800}}) begin
                n_fail++;
                $display("FAIL fixed_word f%0d: got %h expected all 800", f, got);
            end
        end
        check_idle(1);
        n_tests++;
        if (bus.FRAME_CNT !== 16'd3) begin
            n_fail++;
            $display("FAIL frame_cnt_after_3: got %0d expected 3", bus.FRAME_CNT);
        end
        check_idle(2);
    endtask

    task automatic test_en_drop();
        words_t got;
        int     pat = $urandom_range(0, W - 1);
        check_frame(0, pat, BITS, 4, got);
        check_idle(3);
        n_tests++;
        if (got[0] !== BITS'(pat)) begin
            n_fail++;
            $display("FAIL en_drop_word: got %h expected %h", got[0], pat);
        end
    endtask

    task automatic test_checker();
        words_t got;
        logic [BITS-1:0] want [3] = '{12'hAAA, 12'h555, 12'hAAA};
        check_idle(1);
        for (int f = 0; f < 3; f++) begin
            check_frame(2, 0, BITS, -1, got);
            n_tests++;
            if (got !== {N_CH{want[f]}}) begin
                n_fail++;
                $display("FAIL checker_f%0d: got %h expected all %h", f, got, want[f]);
            end
        end
        check_idle(2);
    endtask

    task automatic test_mode3();
        words_t got;
        int     pat = $urandom_range(0, W - 1);
        do_reset();
        check_frame(3, pat, BITS, -1, got);
        n_tests++;
`ifdef ADC_PRBS_EN
        if (got[0][BITS-1 -: 9] !== 9'h1FF) begin
            n_fail++;
            $display("FAIL prbs_first9: got %h expected 1ff", got[0][BITS-1 -: 9]);
        end
`else
        if (got[0] !== BITS'(pat)) begin
            n_fail++;
            $display("FAIL mode3_as_fixed: got %h expected %h", got[0], pat);
        end
`endif
        check_idle(2);
    endtask

    task automatic test_reset_mid();
        words_t got;
        do_reset();
        check_frame(1, 0, BITS, -1, got);
        check_frame(1, 0, BITS, -1, got);
        check_frame(1, 0, 8, -1, got);
        RSTn = 1'b0;
        #2;
        n_tests++;
        if (observed() !== '0) begin
            n_fail++;
            $display("FAIL async_reset_mid: got %h expected 0", observed());
        end
        model_reset();
        #1;
        RSTn = 1'b1;
        check_frame(1, 0, BITS, -1, got);
        n_tests++;
        if (got[0] !== 12'd0 || got[3] !== 12'd3) begin
            n_fail++;
            $display("FAIL ramp_restart: got ch0=%0d ch3=%0d expected 0 3", got[0], got[3]);
        end
        check_idle(2);
    endtask

    task automatic test_random();
        words_t got;
        for (int it = 0; it < 60; it++) begin
            int mode = $urandom_range(0, 3);
            int pat  = $urandom_range(0, W - 1);
            int poke = ($urandom_range(0, 2) == 0) ? $urandom_range(0, BITS - 2) : -1;
            check_frame(mode, pat, BITS, poke, got);
            if ($urandom_range(0, 3) == 0) check_idle($urandom_range(1, 3));
        end
        check_idle(2);
    endtask

    task automatic test_ramp_wrap();
        words_t got;
        do_reset();
        for (int f = 0; f <= 4096; f++) begin
            check_frame(1, 0, BITS, -1, got);
            if (f == 0 || f == 5 || f == 4096) begin
                n_tests++;
                if (got[0] !== BITS'(f % W) || got[3] !== BITS'((f + 3) % W)) begin
                    n_fail++;
                    $display("FAIL ramp_f%0d: got ch0=%0d ch3=%0d expected %0d %0d",
                             f, got[0], got[3], f % W, (f + 3) % W);
                end
            end
        end
        check_idle(2);
    endtask

    initial begin
        test_reset();
        test_fixed();
        test_en_drop();
        test_checker();
        test_mode3();
        test_reset_mid();
        test_random();
        test_ramp_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
